// File: rtl/alarme_pkg.sv
// alarme_pkg: shared alert-code constants, FSM state encoding and input helper
// for the pressure alarm block (alarme_pressao, alarme_filtro).
package alarme_pkg;

    localparam logic [1:0] ALERTA_NORMAL = 2'b00;
    localparam logic [1:0] ALERTA_BAIXA  = 2'b01;
    localparam logic [1:0] ALERTA_ALTA   = 2'b10;
    localparam logic [1:0] ALERTA_INV    = 2'b11;

    localparam int ESTADO_W = 2;

    typedef enum logic [ESTADO_W-1:0] {
        NORMAL      = 2'd0,
        CONFIRMA    = 2'd1,
        ATIVO       = 2'd2,
        RECONHECIDO = 2'd3
    } estado_t;

    // An invalid code is treated as high pressure (fail-safe).
    function automatic logic [1:0] saneia(input logic [1:0] c);
        return (c == ALERTA_INV) ? ALERTA_ALTA : c;
    endfunction

endpackage

// File: rtl/alarme_filtro.sv
// alarme_filtro: counts consecutive samples equal to a reference.
// Ports: clk, rst (async high), sample, reference, clear -> estavel.
module alarme_filtro
    import alarme_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sample,
    input  logic [1:0] reference,
    input  logic       clear,
    output logic       estavel
);

    localparam logic [7:0] ALVO = 8'(DEBOUNCE - 1);
    localparam logic [7:0] TETO = 8'(DEBOUNCE);

    logic [7:0] cnt;
    logic       igual;

    assign igual = (sample == reference);

    // Fires on the sample that brings the run length to DEBOUNCE.
    assign estavel = !clear && igual && (cnt == ALVO);

    // A mismatching sample starts a new run of length one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (!igual) begin
            cnt <= 8'd1;
        end else if (cnt != TETO) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/alarme_pressao.sv
// alarme_pressao: debounces the pressure alert code, latches alarms, drives
// siren/LEDs, waits for acknowledge and counts confirmed alarm events.
// Ports: clk, rst (async high), alerta[1:0], reconhece -> sirene, led_baixa,
// led_alta, estado[1:0], eventos[CNT_W-1:0].
// Option: define ALARME_PISCA_EN to blink the latched LED while in ATIVO.
module alarme_pressao
    import alarme_pkg::*;
#(
    parameter int DEBOUNCE  = 4,
    parameter int CNT_W     = 8,
    parameter int PISCA_DIV = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          alerta,
    input  logic                reconhece,
    output logic                sirene,
    output logic                led_baixa,
    output logic                led_alta,
    output logic [ESTADO_W-1:0] estado,
    output logic [CNT_W-1:0]    eventos
);

    if (DEBOUNCE < 2 || DEBOUNCE > 255) begin : g_chk_deb
        $error("DEBOUNCE out of range");
    end
    if (PISCA_DIV < 1) begin : g_chk_div
        $error("PISCA_DIV must be positive");
    end

    estado_t    estado_q, nxt;
    logic [1:0] alerta_r;
    logic [1:0] lat, lat_n;
    logic [1:0] cand, cand_n;
    logic       inc;
    logic       limpa;
    logic       estavel;
    logic       aceso;

    // lat is 00 outside ATIVO/RECONHECIDO, so one compare covers
    // "back to normal" in the idle states and "latched code" when acked.
    assign limpa = (estado_q == ATIVO) || (alerta_r == lat);

    alarme_filtro #(
        .DEBOUNCE (DEBOUNCE)
    ) u_filtro (
        .clk       (clk),
        .rst       (rst),
        .sample    (alerta_r),
        .reference (cand),
        .clear     (limpa),
        .estavel   (estavel)
    );

    always_comb begin
        nxt    = estado_q;
        lat_n  = lat;
        cand_n = alerta_r;
        inc    = 1'b0;
        unique case (estado_q)
            NORMAL: begin
                if (alerta_r != ALERTA_NORMAL) begin
                    nxt = CONFIRMA;
                end
            end
            CONFIRMA: begin
                if (alerta_r == ALERTA_NORMAL) begin
                    nxt = NORMAL;
                end else if (estavel) begin
                    nxt   = ATIVO;
                    lat_n = alerta_r;
                    inc   = 1'b1;
                end
            end
            ATIVO: begin
                cand_n = lat;
                if (reconhece) begin
                    nxt = RECONHECIDO;
                end
            end
            RECONHECIDO: begin
                if (estavel) begin
                    if (alerta_r == ALERTA_NORMAL) begin
                        nxt   = NORMAL;
                        lat_n = ALERTA_NORMAL;
                    end else begin
                        nxt   = ATIVO;
                        lat_n = alerta_r;
                        inc   = 1'b1;
                    end
                end
            end
        endcase
    end

`ifdef ALARME_PISCA_EN
    logic [15:0] pcnt, pcnt_n;
    logic        fase, fase_n;

    always_comb begin
        pcnt_n = pcnt;
        fase_n = fase;
        if (nxt == ATIVO) begin
            if (estado_q != ATIVO) begin
                pcnt_n = 16'd0;
                fase_n = 1'b1;
            end else if (pcnt == 16'(PISCA_DIV - 1)) begin
                pcnt_n = 16'd0;
                fase_n = ~fase;
            end else begin
                pcnt_n = pcnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= 16'd0;
            fase <= 1'b0;
        end else begin
            pcnt <= pcnt_n;
            fase <= fase_n;
        end
    end

    assign aceso = (nxt == ATIVO) ? fase_n : (nxt == RECONHECIDO);
`else
    assign aceso = (nxt == ATIVO) || (nxt == RECONHECIDO);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= NORMAL;
            alerta_r  <= ALERTA_NORMAL;
            lat       <= ALERTA_NORMAL;
            cand      <= ALERTA_NORMAL;
            eventos   <= '0;
            sirene    <= 1'b0;
            led_baixa <= 1'b0;
            led_alta  <= 1'b0;
        end else begin
            estado_q  <= nxt;
            alerta_r  <= saneia(alerta);
            lat       <= lat_n;
            cand      <= cand_n;
            if (inc && (eventos != {CNT_W{1'b1}})) begin
                eventos <= eventos + 1'b1;
            end
            sirene    <= (nxt == ATIVO);
            led_baixa <= aceso && (lat_n == ALERTA_BAIXA);
            led_alta  <= aceso && (lat_n == ALERTA_ALTA);
        end
    end

    assign estado = estado_q;

endmodule

// File: tb/tb_alarme_pressao.sv
// tb_alarme_pressao: directed self-checking bench for alarme_pressao
// (DEBOUNCE=4, CNT_W=2).
module tb_alarme_pressao;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] alerta;
    logic       reconhece;
    logic       sirene;
    logic       led_baixa;
    logic       led_alta;
    logic [1:0] estado;
    logic [1:0] eventos;

    int errors = 0;
    int checks = 0;

    alarme_pressao #(
        .DEBOUNCE  (4),
        .CNT_W     (2),
        .PISCA_DIV (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alerta    (alerta),
        .reconhece (reconhece),
        .sirene    (sirene),
        .led_baixa (led_baixa),
        .led_alta  (led_alta),
        .estado    (estado),
        .eventos   (eventos)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alerta = 2'b00;
        reconhece = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alerta = 2'b00;
        reconhece = 1'b0;
        repeat (2) tick();
        checks++;
        if (estado !== 2'd0 || sirene !== 1'b0 || eventos !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold: estado=%0d sirene=%b eventos=%0d expected 0 0 0",
                     estado, sirene, eventos);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (estado !== 2'd0 || led_baixa !== 1'b0 || led_alta !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: estado=%0d leds=%b%b expected 0 00",
                     estado, led_baixa, led_alta);
        end
    endtask

    task automatic test_glitch();
        logic visto;
        visto = 1'b0;
        alerta = 2'b10;
        repeat (3) begin
            tick();
            if (estado == 2'd2 || sirene) visto = 1'b1;
        end
        alerta = 2'b00;
        repeat (8) begin
            tick();
            if (estado == 2'd2 || sirene) visto = 1'b1;
        end
        checks++;
        if (visto !== 1'b0) begin
            errors++;
            $display("FAIL glitch_no_alarm: alarm seen=%b expected 0", visto);
        end
        checks++;
        if (estado !== 2'd0 || eventos !== 2'd0) begin
            errors++;
            $display("FAIL glitch_end: estado=%0d eventos=%0d expected 0 0",
                     estado, eventos);
        end
    endtask

    task automatic test_confirm();
        alerta = 2'b01;
        tick();
        checks++;
        if (estado !== 2'd0) begin
            errors++;
            $display("FAIL confirm_e0: estado=%0d expected 0", estado);
        end
        tick();
        checks++;
        if (estado !== 2'd1) begin
            errors++;
            $display("FAIL confirm_e1: estado=%0d expected 1", estado);
        end
        repeat (2) tick();
        checks++;
        if (estado !== 2'd1 || sirene !== 1'b0) begin
            errors++;
            $display("FAIL confirm_e3: estado=%0d sirene=%b expected 1 0",
                     estado, sirene);
        end
        tick();
        checks++;
        if (estado !== 2'd2 || sirene !== 1'b1) begin
            errors++;
            $display("FAIL confirm_e4: estado=%0d sirene=%b expected 2 1",
                     estado, sirene);
        end
        checks++;
        if (led_baixa !== 1'b1 || led_alta !== 1'b0 || eventos !== 2'd1) begin
            errors++;
            $display("FAIL confirm_out: baixa=%b alta=%b eventos=%0d expected 1 0 1",
                     led_baixa, led_alta, eventos);
        end
    endtask

    task automatic test_ack_clear();
        reconhece = 1'b1;
        tick();
        reconhece = 1'b0;
        checks++;
        if (estado !== 2'd3 || sirene !== 1'b0 || led_baixa !== 1'b1) begin
            errors++;
            $display("FAIL ack: estado=%0d sirene=%b baixa=%b expected 3 0 1",
                     estado, sirene, led_baixa);
        end
        alerta = 2'b00;
        repeat (4) tick();
        checks++;
        if (estado !== 2'd3 || led_baixa !== 1'b1) begin
            errors++;
            $display("FAIL clear_early: estado=%0d baixa=%b expected 3 1",
                     estado, led_baixa);
        end
        tick();
        checks++;
        if (estado !== 2'd0 || led_baixa !== 1'b0 || sirene !== 1'b0) begin
            errors++;
            $display("FAIL clear: estado=%0d baixa=%b sirene=%b expected 0 0 0",
                     estado, led_baixa, sirene);
        end
    endtask

    task automatic test_escalation();
        do_reset();
        alerta = 2'b01;
        repeat (5) tick();
        reconhece = 1'b1;
        tick();
        reconhece = 1'b0;
        checks++;
        if (estado !== 2'd3) begin
            errors++;
            $display("FAIL esc_ack: estado=%0d expected 3", estado);
        end
        alerta = 2'b10;
        repeat (4) tick();
        checks++;
        if (estado !== 2'd3 || sirene !== 1'b0) begin
            errors++;
            $display("FAIL esc_early: estado=%0d sirene=%b expected 3 0",
                     estado, sirene);
        end
        tick();
        checks++;
        if (estado !== 2'd2 || sirene !== 1'b1) begin
            errors++;
            $display("FAIL esc_state: estado=%0d sirene=%b expected 2 1",
                     estado, sirene);
        end
        checks++;
        if (led_alta !== 1'b1 || led_baixa !== 1'b0 || eventos !== 2'd2) begin
            errors++;
            $display("FAIL esc_out: alta=%b baixa=%b eventos=%0d expected 1 0 2",
                     led_alta, led_baixa, eventos);
        end
    endtask

    task automatic test_invalid();
        do_reset();
        reconhece = 1'b1;
        alerta = 2'b11;
        repeat (5) tick();
        checks++;
        if (estado !== 2'd2 || led_alta !== 1'b1 || led_baixa !== 1'b0) begin
            errors++;
            $display("FAIL invalid: estado=%0d alta=%b baixa=%b expected 2 1 0",
                     estado, led_alta, led_baixa);
        end
        checks++;
        if (eventos !== 2'd1) begin
            errors++;
            $display("FAIL invalid_cnt: eventos=%0d expected 1", eventos);
        end
        tick();
        reconhece = 1'b0;
        checks++;
        if (estado !== 2'd3 || led_alta !== 1'b1) begin
            errors++;
            $display("FAIL held_ack: estado=%0d alta=%b expected 3 1",
                     estado, led_alta);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alerta = 2'b01;
            repeat (5) tick();
            reconhece = 1'b1;
            tick();
            reconhece = 1'b0;
            alerta = 2'b00;
            repeat (5) tick();
            if (i == 3) begin
                checks++;
                if (eventos !== 2'd3) begin
                    errors++;
                    $display("FAIL sat_4: eventos=%0d expected 3", eventos);
                end
            end
        end
        checks++;
        if (eventos !== 2'd3 || estado !== 2'd0) begin
            errors++;
            $display("FAIL sat_5: eventos=%0d estado=%0d expected 3 0",
                     eventos, estado);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        alerta = 2'b10;
        repeat (5) tick();
        checks++;
        if (estado !== 2'd2 || eventos !== 2'd1) begin
            errors++;
            $display("FAIL async_pre: estado=%0d eventos=%0d expected 2 1",
                     estado, eventos);
        end
        #2;
        rst = 1'b1;
        alerta = 2'b00;
        #1;
        checks++;
        if (sirene !== 1'b0 || led_alta !== 1'b0 || estado !== 2'd0 ||
            eventos !== 2'd0) begin
            errors++;
            $display("FAIL async_rst: sirene=%b alta=%b estado=%0d eventos=%0d expected 0 0 0 0",
                     sirene, led_alta, estado, eventos);
        end
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if (estado !== 2'd0 || eventos !== 2'd0) begin
            errors++;
            $display("FAIL async_post: estado=%0d eventos=%0d expected 0 0",
                     estado, eventos);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_confirm();
        test_ack_clear();
        test_escalation();
        test_invalid();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarme_pressao.md
Name: alarme_pressao

Overview:
- Consumer of the 2-bit pressure alert code produced by the combinational pressure monitor.
- Registers and debounces the code, then latches a confirmed alarm. Drives the siren and the low/high LEDs, waits for an operator acknowledge, and clears only after a stable return to normal.
- Counts confirmed alarm events for the supervisory panel.

Parameters:
- DEBOUNCE, 4: consecutive equal samples needed to confirm a code change; legal range 2..255.
- CNT_W, 8: width of the event counter.
- PISCA_DIV, 8: blink half-period in clk cycles; used only with ALARME_PISCA_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alerta  in  2  alert code from the monitor: 00 normal, 01 low, 10 high, 11 invalid.
- reconhece  in  1  operator acknowledge; level sampled each clk.
- sirene  out  1  siren drive.
- led_baixa  out  1  low-pressure LED.
- led_alta  out  1  high-pressure LED.
- estado  out  2  current FSM state.
- eventos  out  CNT_W  confirmed-alarm count, saturating.

Behaviour:
- Reset is asynchronous and active-high. While rst=1 or after its release:
  - estado = NORMAL; sirene, led_baixa, led_alta = 0; eventos = 0.
  - Internal alerta_r = 00, debounce count = 0, latched code = 00.
- Input stage:
  - alerta is registered into alerta_r every edge.
  - Code 11 is mapped to 10 (fail-safe high) before any comparison.
- States, with estado encoding: NORMAL = 0, CONFIRMA = 1, ATIVO = 2, RECONHECIDO = 3.
- NORMAL:
  - alerta_r nonzero → CONFIRMA, with candidate = alerta_r and count = 1.
- CONFIRMA:
  - alerta_r == candidate → count + 1. On the edge where the count reaches DEBOUNCE → ATIVO, latched code = candidate, eventos + 1.
  - alerta_r == 00 → NORMAL, count = 0.
  - alerta_r is a different nonzero code → stay in CONFIRMA, candidate = new code, count = 1.
- ATIVO:
  - sirene = 1. The LED matching the latched code = 1; the other LED = 0.
  - reconhece = 1 → RECONHECIDO at the next edge.
  - Changes on alerta_r are ignored in this state.
- RECONHECIDO:
  - sirene = 0; the latched LED stays on, steady.
  - alerta_r == 00 for DEBOUNCE consecutive samples → NORMAL, both LEDs = 0.
  - alerta_r is the other nonzero code for DEBOUNCE consecutive samples → ATIVO with the new latched code, eventos + 1.
  - alerta_r equal to the latched code resets the debounce count to 0.
- reconhece is ignored outside ATIVO. A held reconhece does not pre-acknowledge a future alarm: it is level-checked only while in ATIVO.
- Latency: if alerta changes before edge E0, estado = ATIVO is visible after edge E(DEBOUNCE), i.e. DEBOUNCE+1 edges after the change. A pulse shorter than DEBOUNCE samples never raises an alarm.
- eventos saturates at 2^CNT_W − 1 and never wraps.
- Outputs are registered, updated on the state-transition edge.
- Reset asserted mid-operation returns everything immediately to the reset values; the event count is lost.

Optional Feature:
- Macro: ALARME_PISCA_EN.
- Defined: in ATIVO the latched LED toggles every PISCA_DIV cycles. It starts lit on the ATIVO entry edge, and the blink counter restarts on each entry to ATIVO. sirene stays steady.
- Not defined: the LED is steady in ATIVO and the blink counter logic is absent.
- RECONHECIDO is steady in both builds.

Decomposition:
- Package alarme_pkg holds:
  - alert code constants: ALERTA_NORMAL, ALERTA_BAIXA, ALERTA_ALTA, ALERTA_INV;
  - state constants NORMAL, CONFIRMA, ATIVO, RECONHECIDO, plus their 2-bit width.
- One sub-module, alarme_filtro: the consecutive-equal-sample counter.
  - Inputs: sample, reference, clear.
  - Output: estavel, asserted when the count reaches DEBOUNCE.
  - Shared by the CONFIRMA and RECONHECIDO paths.

Test Plan:
- Confirm: DEBOUNCE=4; alerta=01 from idle, held → estado 1 after E1, estado 2 after E4; sirene=1, led_baixa=1, led_alta=0, eventos=1.
- Glitch reject: alerta=10 for 3 cycles, then 00 → never reaches ATIVO, returns to estado 0, eventos=0, sirene stays 0.
- Acknowledge and clear:
  - In ATIVO (low), reconhece=1 for 1 cycle → sirene=0 next edge, led_baixa=1, estado=3.
  - Then alerta=00 held 4 cycles → estado=0, led_baixa=0.
- Escalation: in RECONHECIDO (low), alerta=10 held 4 samples → estado=2, led_alta=1, led_baixa=0, sirene=1, eventos=2.
- Invalid/saturation:
  - alerta=11 held 4 samples → treated as high, led_alta=1.
  - With CNT_W=2, 5 alarm cycles → eventos=3.
- Async reset: rst pulsed mid-ATIVO between edges → outputs go to 0 without a clock edge; after release, estado=0 and eventos=0.
